// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO and back-to-back framing.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 2604,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 trmt,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 TX
);

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_LEN = 1 + DATA_BITS + P + STOP_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] TRANSMIT = 1'b1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [0:0]           state;
  logic [FRAME_LEN-1:0] sreg;
  logic [FRAME_LEN-1:0] frame;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] head;
  logic                 shift;
  logic                 frame_end;
  logic                 pop;
  logic                 wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign shift     = (state == TRANSMIT) && (baud_cnt == BAUD_MAX);
  assign frame_end = shift && (bit_cnt == LAST_BIT);
  assign pop       = !empty && ((state == IDLE) || frame_end);
  // A pop on the same edge frees the slot, so a write at full still fits.
  assign wr        = trmt && (!full || pop);

`ifdef UART_TX_PARITY_EN
  logic par;
  assign par   = (^head) ^ 1'(PARITY_ODD);
  assign frame = {{STOP_BITS{1'b1}}, par, head, 1'b0};
`else
  assign frame = {{STOP_BITS{1'b1}}, head, 1'b0};
`endif

  assign busy = (state == TRANSMIT);
  assign TX   = sreg[0];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= trmt && full && !pop;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (pop) begin
        state    <= TRANSMIT;
        sreg     <= frame;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (frame_end) begin
        state    <= IDLE;
        sreg     <= {1'b1, sreg[FRAME_LEN-1:1]};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (shift) begin
        sreg     <= {1'b1, sreg[FRAME_LEN-1:1]};
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + CW'(1);
      end else if (state == TRANSMIT) begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 even, 8N1 odd, 5-bit 2-stop).
// Frames are scoreboarded bit by bit by a per-instance line monitor.
module tb_uart_tx_fifo;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] EXP_A5 = 16'hFD4A;
  localparam logic EP07_EVEN = 1'b1;
  localparam logic EP07_ODD  = 1'b0;
  localparam logic EP03_EVEN = 1'b0;
  localparam logic EP03_ODD  = 1'b1;
`else
  localparam int PB = 0;
  localparam logic [15:0] EXP_A5 = 16'hFF4A;
  localparam logic EP07_EVEN = 1'b1;
  localparam logic EP07_ODD  = 1'b1;
  localparam logic EP03_EVEN = 1'b1;
  localparam logic EP03_ODD  = 1'b1;
`endif
  localparam logic [15:0] EXP_13 = 16'hFFE6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] trmt_v = '0;
  logic [2:0] full_v, empty_v, ovf_v, busy_v, done_v, tx_v;
  logic [7:0] d0 = '0;
  logic [7:0] d1 = '0;
  logic [4:0] d2 = '0;

  int vectors = 0;
  int errs = 0;
  int nframes [3];
  logic [15:0] last [3];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .trmt(trmt_v[0]),
    .full(full_v[0]), .empty(empty_v[0]), .overflow(ovf_v[0]),
    .busy(busy_v[0]), .tx_done(done_v[0]), .TX(tx_v[0]));

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .trmt(trmt_v[1]),
    .full(full_v[1]), .empty(empty_v[1]), .overflow(ovf_v[1]),
    .busy(busy_v[1]), .tx_done(done_v[1]), .TX(tx_v[1]));

  uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
                 .FIFO_DEPTH(4), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .trmt(trmt_v[2]),
    .full(full_v[2]), .empty(empty_v[2]), .overflow(ovf_v[2]),
    .busy(busy_v[2]), .tx_done(done_v[2]), .TX(tx_v[2]));

  function automatic int dbits(int id);
    return (id == 2) ? 5 : 8;
  endfunction

  function automatic int flen(int id);
    return 1 + dbits(id) + PB + ((id == 2) ? 2 : 1);
  endfunction

  // Expected line bits, index 0 first on the wire, unused bits high.
  function automatic logic [15:0] build(int id, logic [7:0] d);
    logic [15:0] f;
    logic p;
    f = '1;
    f[0] = 1'b0;
    p = (id == 1);
    for (int i = 0; i < dbits(id); i++) begin
      f[1+i] = d[i];
      p = p ^ d[i];
    end
    if (PB == 1) f[1+dbits(id)] = p;
    return f;
  endfunction

  function automatic int qsize(int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(int id, logic [15:0] f);
    case (id)
      0: q0.push_back(f);
      1: q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  task automatic qpop(int id, output logic [15:0] f);
    case (id)
      0: f = q0.pop_front();
      1: f = q1.pop_front();
      default: f = q2.pop_front();
    endcase
  endtask

  task automatic qclear(int id);
    case (id)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic monitor(int id);
    int cyc;
    int fl;
    bit act;
    logic [15:0] exp_f;
    logic [15:0] got;
    fl = flen(id);
    act = 0;
    cyc = 0;
    exp_f = '1;
    got = '1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 0;
        qclear(id);
        continue;
      end
      if (act) begin
        if ((cyc % CPB) == CPB/2 && (cyc / CPB) < fl) begin
          vectors++;
          got[cyc/CPB] = tx_v[id];
          if (tx_v[id] !== exp_f[cyc/CPB]) begin
            errs++;
            $display("FAIL dut%0d line bit%0d: got %b, want %b",
                     id, cyc / CPB, tx_v[id], exp_f[cyc/CPB]);
          end
        end
        if (cyc == CPB/2) begin
          vectors++;
          if (busy_v[id] !== 1'b1) begin
            errs++;
            $display("FAIL dut%0d busy in frame: got %b, want 1", id, busy_v[id]);
          end
        end
        if (cyc == fl*CPB - 1) begin
          vectors++;
          if (done_v[id] !== 1'b0) begin
            errs++;
            $display("FAIL dut%0d tx_done early: got %b, want 0", id, done_v[id]);
          end
        end
        if (cyc == fl*CPB) begin
          vectors++;
          if (done_v[id] !== 1'b1) begin
            errs++;
            $display("FAIL dut%0d tx_done at end: got %b, want 1", id, done_v[id]);
          end
          act = 0;
          last[id] = got;
          nframes[id]++;
          if (qsize(id) > 0) begin
            vectors++;
            if (tx_v[id] !== 1'b0) begin
              errs++;
              $display("FAIL dut%0d back-to-back gap: got TX=%b, want 0", id, tx_v[id]);
            end
          end
        end
        cyc++;
      end
      if (!act && tx_v[id] === 1'b0) begin
        act = 1;
        cyc = 1;
        got = '1;
        if (qsize(id) == 0) begin
          vectors++;
          errs++;
          $display("FAIL dut%0d unexpected frame: got start bit, want idle", id);
          exp_f = '1;
        end else begin
          qpop(id, exp_f);
        end
      end
    end
  endtask

  task automatic write(int id, logic [7:0] d, bit accept);
    case (id)
      0: d0 = d;
      1: d1 = d;
      default: d2 = d[4:0];
    endcase
    trmt_v[id] = 1'b1;
    if (accept) qpush(id, build(id, d));
    @(posedge clk);
    #1 trmt_v[id] = 1'b0;
  endtask

  task automatic wait_frames(int id, int target, int budget);
    int n;
    n = 0;
    while (nframes[id] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (nframes[id] < target) begin
      errs++;
      $display("FAIL dut%0d frame wait: got %0d frames, want %0d", id, nframes[id], target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({tx_v[0], done_v[0], busy_v[0], full_v[0], empty_v[0], ovf_v[0]} !== 6'b100010) begin
      errs++;
      $display("FAIL reset state: got %b, want 100010",
               {tx_v[0], done_v[0], busy_v[0], full_v[0], empty_v[0], ovf_v[0]});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int base;
    base = nframes[0];
    write(0, 8'hA5, 1);
    vectors++;
    if (empty_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
      errs++;
      $display("FAIL single latency: got empty=%b TX=%b, want 0 1", empty_v[0], tx_v[0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      errs++;
      $display("FAIL single start: got TX=%b busy=%b, want 0 1", tx_v[0], busy_v[0]);
    end
    wait_frames(0, base + 1, 400);
    vectors++;
    if (last[0] !== EXP_A5) begin
      errs++;
      $display("FAIL single A5 bits: got %h, want %h", last[0], EXP_A5);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
      errs++;
      $display("FAIL single after: got busy=%b done=%b TX=%b, want 0 0 1",
               busy_v[0], done_v[0], tx_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = nframes[0];
    write(0, 8'h00, 1);
    write(0, 8'hFF, 1);
    write(0, 8'h55, 1);
    write(0, 8'h3C, 1);
    wait_frames(0, base + 4, 4 * flen(0) * CPB + 50);
    @(posedge clk);
    #1;
    vectors++;
    if (busy_v[0] !== 1'b0 || empty_v[0] !== 1'b1) begin
      errs++;
      $display("FAIL b2b drain: got busy=%b empty=%b, want 0 1", busy_v[0], empty_v[0]);
    end
  endtask

  task automatic test_overflow();
    int base;
    base = nframes[0];
    write(0, 8'h11, 1);
    repeat (2) @(posedge clk);
    #1;
    write(0, 8'h22, 1);
    write(0, 8'h33, 1);
    write(0, 8'h44, 1);
    vectors++;
    if (full_v[0] !== 1'b0) begin
      errs++;
      $display("FAIL overflow three queued: got full=%b, want 0", full_v[0]);
    end
    write(0, 8'h55, 1);
    vectors++;
    if (full_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
      errs++;
      $display("FAIL overflow fill: got full=%b ovf=%b, want 1 0", full_v[0], ovf_v[0]);
    end
    write(0, 8'h99, 0);
    vectors++;
    if (ovf_v[0] !== 1'b1 || full_v[0] !== 1'b1) begin
      errs++;
      $display("FAIL overflow pulse: got ovf=%b full=%b, want 1 1", ovf_v[0], full_v[0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (ovf_v[0] !== 1'b0) begin
      errs++;
      $display("FAIL overflow width: got ovf=%b, want 0", ovf_v[0]);
    end
    wait_frames(0, base + 5, 5 * flen(0) * CPB + 50);
    repeat (2 * flen(0) * CPB) @(posedge clk);
    #1;
    vectors++;
    if (busy_v[0] !== 1'b0 || nframes[0] !== base + 5) begin
      errs++;
      $display("FAIL overflow drop: got busy=%b frames=%0d, want 0 %0d",
               busy_v[0], nframes[0], base + 5);
    end
  endtask

  task automatic test_parity();
    int b0;
    int b1;
    b0 = nframes[0];
    b1 = nframes[1];
    write(0, 8'h07, 1);
    write(1, 8'h07, 1);
    wait_frames(0, b0 + 1, flen(0) * CPB + 50);
    wait_frames(1, b1 + 1, flen(1) * CPB + 50);
    vectors++;
    if (last[0][9] !== EP07_EVEN || last[1][9] !== EP07_ODD) begin
      errs++;
      $display("FAIL parity 07: got even=%b odd=%b, want %b %b",
               last[0][9], last[1][9], EP07_EVEN, EP07_ODD);
    end
    write(0, 8'h03, 1);
    write(1, 8'h03, 1);
    wait_frames(0, b0 + 2, flen(0) * CPB + 50);
    wait_frames(1, b1 + 2, flen(1) * CPB + 50);
    vectors++;
    if (last[0][9] !== EP03_EVEN || last[1][9] !== EP03_ODD) begin
      errs++;
      $display("FAIL parity 03: got even=%b odd=%b, want %b %b",
               last[0][9], last[1][9], EP03_EVEN, EP03_ODD);
    end
  endtask

  task automatic test_five_bit();
    int base;
    base = nframes[2];
    write(2, 8'h13, 1);
    wait_frames(2, base + 1, flen(2) * CPB + 50);
    vectors++;
    if (last[2] !== EXP_13) begin
      errs++;
      $display("FAIL five-bit 13 bits: got %h, want %h", last[2], EXP_13);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    write(0, 8'hA1, 1);
    write(0, 8'hB2, 1);
    write(0, 8'hC3, 1);
    repeat (68) @(posedge clk);
    #1;
    vectors++;
    if (tx_v[0] !== 1'b0) begin
      errs++;
      $display("FAIL mid-frame bit3: got TX=%b, want 0", tx_v[0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_v[0] !== 1'b1 || empty_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      errs++;
      $display("FAIL async reset: got TX=%b empty=%b busy=%b, want 1 1 0",
               tx_v[0], empty_v[0], busy_v[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = nframes[0];
    repeat (300) @(posedge clk);
    #1;
    vectors++;
    if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || nframes[0] !== base) begin
      errs++;
      $display("FAIL post-reset idle: got busy=%b TX=%b frames=%0d, want 0 1 %0d",
               busy_v[0], tx_v[0], nframes[0], base);
    end
    write(0, 8'h5A, 1);
    wait_frames(0, base + 1, flen(0) * CPB + 50);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      nframes[i] = 0;
      last[i] = '1;
    end
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_five_bit();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

endmodule
